control_override_unit: RTL
==========================

// Module: control_override_unit
// PURPOSE
//  Drive-side counterpart of the observe path in the SoC patch fabric: applies patch
//  overrides to signals tagged as control points.
//  Receives a serial patch configuration from the patch loader and arms on it. When the
//  trigger (from observe/trigger logic) fires, forces or inverts the selected control
//  signals for a programmed number of cycles, then re-arms.
//  Sits inline between the original driver (sig_in) and the consuming logic (sig_out).
// PARAMETERS
//  NUM_SIG  4  number of control signals handled
//  CNT_W    8  width of override duration field and counter
//  CFG_LEN  2*NUM_SIG+CNT_W+1 (derived, localparam)  config frame length in bits; 17 at defaults
// PORTS
//  clk             in   1        single clock, all state on rising edge
//  rst_n           in   1        asynchronous, active-low reset
//  cfg_valid       in   1        cfg_bit is valid this cycle
//  cfg_bit         in   1        serial config data
//  cfg_ready       out  1        unit accepts a config bit this cycle
//  disarm          in   1        synchronous clear of config, return to IDLE
//  trigger         in   1        override request (level, sampled per cycle)
//  sig_in          in   NUM_SIG  original control signal values
//  sig_out         out  NUM_SIG  patched control signal values
//  override_active out  1        high while in OVERRIDE
//  done            out  1        one-cycle pulse when a timed override ends
// BEHAVIOUR
//  Reset state: state IDLE; shift register, bit counter, mask, value, duration, mode and
//   down-counter all 0; override_active=0; done=0; cfg_ready=1; sig_out=sig_in.
//  Config frame:
//   - A bit is accepted on a cycle with cfg_valid & cfg_ready, and is shifted in as
//     shreg <= {shreg[CFG_LEN-2:0], cfg_bit}, so the first bit received ends up as the MSB.
//   - Frame layout, MSB to LSB: mode[1] | duration[CNT_W] | value[NUM_SIG] | mask[NUM_SIG].
//   - When the CFG_LEN-th bit is accepted, the full frame is latched into the active
//     registers in that cycle and the bit counter clears.
//  States:
//   - IDLE:     accepted bit -> LOAD.
//   - LOAD:     last bit accepted -> ARMED. cfg_valid low simply stalls; there is no timeout.
//   - ARMED:    accepted bit -> LOAD. This discards the armed config, and the new frame
//               restarts at bit 0. Otherwise trigger=1 -> OVERRIDE, with down-counter <= duration.
//   - OVERRIDE: duration!=0 -> counter decrements each cycle; in the cycle the counter is 1,
//               next state is ARMED and done=1 in the following cycle. Config is retained
//               for re-triggering. duration==0 -> persistent override until disarm.
//  cfg_ready = 1 in IDLE, LOAD and ARMED; 0 in OVERRIDE.
//  Datapath: sig_out is combinational from sig_in and state.
//   - Not in OVERRIDE: sig_out = sig_in.
//   - OVERRIDE, mode 0 (force):  sig_out = (sig_in & ~mask) | (value & mask).
//   - OVERRIDE, mode 1 (invert): sig_out = sig_in ^ mask.
//  Latency: trigger sampled high at edge t -> override visible from cycle t+1 for exactly
//   duration cycles.
//  Boundary and priority rules:
//   - disarm has top priority from any state. It returns to IDLE next cycle, clears the
//     config regs and bit counter, and drops the override immediately at that edge.
//     done stays 0.
//   - ARMED with trigger and an accepted bit in the same cycle: the config bit wins, the
//     next state is LOAD, and the trigger is ignored.
//   - trigger during OVERRIDE is ignored; the counter is not reloaded.
//   - trigger in the cycle done=1 (first cycle back in ARMED) is accepted.
//   - mask=0 -> OVERRIDE still runs its timing, but sig_out equals sig_in.
//   - Asynchronous reset mid-frame or mid-override -> immediate reset state; no done pulse.
// TESTING
//  1. Reset, then a frame mode=0, dur=3, val=4'b1010, mask=4'b0110, sig_in=4'b0000, then
//     trigger 1 cycle -> sig_out=4'b0010 for exactly 3 cycles, done pulse, re-armed.
//  2. Same frame with mode=1, sig_in=4'b1111 -> sig_out=4'b1001 for 3 cycles; a trigger
//     held high re-fires on the done cycle.
//  3. dur=0 frame, trigger -> override persists for more than 300 cycles and cfg_ready
//     stays 0; disarm -> passthrough next cycle, state IDLE, done never pulses.
//  4. ARMED, cfg bit and trigger in the same cycle -> no override, LOAD entered; a fresh
//     17-bit frame re-arms with the new config.
//  5. cfg_valid gaps mid-frame plus a trigger while in LOAD -> no override; the frame
//     completes correctly after the gaps.
//  6. rst_n asserted during OVERRIDE, asynchronously between edges -> sig_out=sig_in and
//     override_active=0 immediately; unit is back in IDLE.

Source files
------------

// File: rtl/control_override_unit.sv
// Inline override stage for tagged control signals: loads a serial patch frame, arms,
// then forces or inverts the selected signals for a timed or persistent window once triggered.
module control_override_unit #(
  parameter int NUM_SIG = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  input  logic               cfg_bit,
  output logic               cfg_ready,
  input  logic               disarm,
  input  logic               trigger,
  input  logic [NUM_SIG-1:0] sig_in,
  output logic [NUM_SIG-1:0] sig_out,
  output logic               override_active,
  output logic               done,
  output logic [1:0]         dbg_state
);
  localparam int CFG_LEN = 2*NUM_SIG + CNT_W + 1;
  localparam int BC_W    = $clog2(CFG_LEN + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, ARMED = 2'd2, OVERRIDE = 2'd3} state_t;

  state_t               state, state_nxt;
  logic [CFG_LEN-1:0]   shreg;
  logic [CFG_LEN-1:0]   frame;
  logic [BC_W-1:0]      bit_cnt;
  logic [NUM_SIG-1:0]   mask, value;
  logic [CNT_W-1:0]     duration, cnt;
  logic                 mode;
  logic                 accept, last_bit, fire, expire;

  // Config handshake: a bit transfers on any cycle with cfg_valid & cfg_ready;
  // cfg_ready is low only while an override is running.
  assign cfg_ready = (state != OVERRIDE);
  assign accept    = cfg_valid & cfg_ready;
  assign frame     = {shreg[CFG_LEN-2:0], cfg_bit};
  assign last_bit  = accept && (bit_cnt == BC_W'(CFG_LEN-1));
  // A config bit arriving while armed wins over a simultaneous trigger.
  assign fire      = (state == ARMED) && !accept && trigger && !disarm;
  assign expire    = (state == OVERRIDE) && (duration != '0) && (cnt == CNT_W'(1));

  assign override_active = (state == OVERRIDE);
  assign dbg_state       = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (disarm) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (accept)   state_nxt = LOAD;
        LOAD:     if (last_bit) state_nxt = ARMED;
        ARMED:    if (accept)   state_nxt = LOAD;
                  else if (fire) state_nxt = OVERRIDE;
        OVERRIDE: if (expire)   state_nxt = ARMED;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      mask     <= '0;
      value    <= '0;
      duration <= '0;
      mode     <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
    end else if (disarm) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      mask     <= '0;
      value    <= '0;
      duration <= '0;
      mode     <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
    end else begin
      done <= expire;
      if (accept) begin
        shreg <= frame;
        if (last_bit) begin
          bit_cnt                       <= '0;
          {mode, duration, value, mask} <= frame;
        end else begin
          bit_cnt <= bit_cnt + BC_W'(1);
        end
      end
      // Zero duration means persistent: the counter simply stays at zero.
      if (fire)
        cnt <= duration;
      else if (state == OVERRIDE && cnt != '0)
        cnt <= cnt - CNT_W'(1);
    end
  end

  always_comb begin
    sig_out = sig_in;
    if (state == OVERRIDE) begin
      if (mode) sig_out = sig_in ^ mask;
      else      sig_out = (sig_in & ~mask) | (value & mask);
    end
  end
endmodule
